ex_alu_stage: RTL and testbench
===============================

EX_ALU_STAGE -- requirements
Module: ex_alu_stage

Interface
REQ-001 Parameter UNDEF_FUNCT_ADD, default 1, meaning: 1 = undefined funct under R-type executes ADD; 0 = result forced to 0.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 en  input  1  1 = capture new stage inputs on next edge; 0 = hold registered state.
REQ-005 alu_op  input  4  ALU class from main decoder.
REQ-006 funct  input  6  instruction bits [5:0].
REQ-007 op  input  6  instruction opcode [31:26], used for byte enables.
REQ-008 a  input  32  operand A (register value or zero-extended shamt).
REQ-009 b  input  32  operand B (register value or immediate).
REQ-010 result  output  64  registered ALU result; [63:32] nonzero only for multiply.
REQ-011 zero  output  1  registered, result[31:0]==0.
REQ-012 sign  output  1  registered, result[31].
REQ-013 ovf  output  1  registered signed overflow of ADD/SUB only.
REQ-014 be  output  4  byte enables, combinational from registered op and result[1:0].
REQ-015 u  output  1  unsigned-load flag, combinational from registered op.

Function
REQ-016 alu_op decode: 0000 ADD, 0001 SUB, 0010 use funct, 0011 AND, 0100 OR, 0101 XOR, 0110 SLT, 0111 SLTU, 1000 LUI, 1001 ADDU; 1010-1111 ADD.
REQ-017 funct decode (alu_op=0010): 20 ADD, 21 ADDU, 22 SUB, 23 SUBU, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU, 00 SLL, 02 SRL, 03 SRA, 04 SLLV, 06 SRLV, 07 SRAV, 18 MULT, 19 MULTU (hex); others per UNDEF_FUNCT_ADD.
REQ-018 ADD/ADDU/SUB/SUBU: 32-bit wrap-around a±b; ovf set only for ADD/SUB on signed overflow; ADDU/SUBU never set ovf.
REQ-019 Logic ops bitwise on 32 bits; NOR = ~(a|b).
REQ-020 SLT: 1 if $signed(a)<$signed(b) else 0; SLTU unsigned compare; upper 31 bits 0.
REQ-021 All shifts shift b by a[4:0]; SRA/SRAV replicate b[31]; a[31:5] ignored.
REQ-022 LUI: b<<16.
REQ-023 MULT: signed 64-bit a*b; MULTU: unsigned 64-bit; all other ops drive result[63:32]=0.
REQ-024 Latency one cycle: inputs sampled at edge with en=1 appear on result/zero/sign/ovf after that edge; op also registered then.
REQ-025 be from registered op and result[1:0]: LB/LBU/SB (20,24,28) = 0001<<addr; LH/LHU/SH (21,25,29) = addr[1]?1100:0011, addr[0] ignored; LW/SW (23,2B) = 1111; all other ops 0000.
REQ-026 u=1 only for LBU(24) and LHU(25).
REQ-027 en=0 holds result, flags and op; be/u therefore also stable.

Reset
REQ-028 reset=1 immediately (no clock) clears result, zero's source, sign, ovf and registered op to 0; zero output reads 1, be 0000, u 0.
REQ-029 Reset asserted mid-operation discards the in-flight operation; first capture occurs on the first rising edge with reset=0 and en=1.

Configuration
REQ-030 Macro EX_ALU_STAGE_MULT_EN: defined = MULT/MULTU implemented per REQ-023; undefined = MULT/MULTU produce result 0 (zero=1) and no multiplier is synthesized.

Verification
REQ-031 alu_op=0010, funct=20, a=7FFFFFFF, b=1, one edge -> result=80000000, ovf=1, sign=1, zero=0; same with funct=21 -> ovf=0.
REQ-032 alu_op=0010, funct=03, a=4, b=F0000000 -> result=FF000000; funct=02 -> 0F000000; funct=00 with a=24 (shamt 4 via a[4:0]) -> 00000000, zero=1.
REQ-033 alu_op=0110, a=FFFFFFFF, b=1 -> result=1; alu_op=0111 same operands -> 0; alu_op=1000, b=1234 -> 12340000.
REQ-034 macro defined: funct=18, a=FFFFFFFE, b=3 -> result=FFFFFFFF_FFFFFFFA; funct=19 -> 00000002_FFFFFFFA; macro undefined -> 0.
REQ-035 op=28, result[1:0]=3 -> be=1000, u=0; op=25, addr 2 -> be=1100, u=1; op=2B -> 1111; op=0F -> 0000.
REQ-036 Load nonzero result, drop en -> outputs hold across 3 edges; assert reset between edges -> outputs clear at once, be=0000.

Source files
------------

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with one-cycle registered result, flags and load/store byte enables.
// Define EX_ALU_STAGE_MULT_EN to implement MULT/MULTU; otherwise they return 0.
module ex_alu_stage #(
  parameter bit UNDEF_FUNCT_ADD = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        zero,
  output logic        sign,
  output logic        ovf,
  output logic [3:0]  be,
  output logic        u
);

  typedef enum logic [4:0] {
    K_ADD, K_ADDU, K_SUB, K_SUBU, K_AND, K_OR, K_XOR, K_NOR,
    K_SLT, K_SLTU, K_SLL, K_SRL, K_SRA, K_LUI, K_MULT, K_MULTU, K_ZERO
  } kind_e;

  kind_e       kind;
  logic [31:0] sum, diff;
  logic [4:0]  shamt;
  logic [63:0] result_d, result_q;
  logic        ovf_d, ovf_q;
  logic [5:0]  op_q;

  always_comb begin
    kind = K_ADD;
    unique case (alu_op)
      4'b0000: kind = K_ADD;
      4'b0001: kind = K_SUB;
      4'b0011: kind = K_AND;
      4'b0100: kind = K_OR;
      4'b0101: kind = K_XOR;
      4'b0110: kind = K_SLT;
      4'b0111: kind = K_SLTU;
      4'b1000: kind = K_LUI;
      4'b1001: kind = K_ADDU;
      4'b0010: begin
        case (funct)
          6'h20: kind = K_ADD;
          6'h21: kind = K_ADDU;
          6'h22: kind = K_SUB;
          6'h23: kind = K_SUBU;
          6'h24: kind = K_AND;
          6'h25: kind = K_OR;
          6'h26: kind = K_XOR;
          6'h27: kind = K_NOR;
          6'h2A: kind = K_SLT;
          6'h2B: kind = K_SLTU;
          6'h00, 6'h04: kind = K_SLL;
          6'h02, 6'h06: kind = K_SRL;
          6'h03, 6'h07: kind = K_SRA;
          6'h18: kind = K_MULT;
          6'h19: kind = K_MULTU;
          default: kind = UNDEF_FUNCT_ADD ? K_ADD : K_ZERO;
        endcase
      end
      default: kind = K_ADD;
    endcase
  end

`ifdef EX_ALU_STAGE_MULT_EN
  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};
`endif

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = a[4:0];

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    case (kind)
      K_ADD: begin
        result_d[31:0] = sum;
        ovf_d = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      K_ADDU: result_d[31:0] = sum;
      K_SUB: begin
        result_d[31:0] = diff;
        ovf_d = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      K_SUBU: result_d[31:0] = diff;
      K_AND:  result_d[31:0] = a & b;
      K_OR:   result_d[31:0] = a | b;
      K_XOR:  result_d[31:0] = a ^ b;
      K_NOR:  result_d[31:0] = ~(a | b);
      K_SLT:  result_d[0] = $signed(a) < $signed(b);
      K_SLTU: result_d[0] = a < b;
      K_SLL:  result_d[31:0] = b << shamt;
      K_SRL:  result_d[31:0] = b >> shamt;
      K_SRA:  result_d[31:0] = $signed(b) >>> shamt;
      K_LUI:  result_d[31:0] = b << 16;
`ifdef EX_ALU_STAGE_MULT_EN
      K_MULT:  result_d = prod_s;
      K_MULTU: result_d = prod_u;
`endif
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      op_q     <= '0;
    end else if (en) begin
      result_q <= result_d;
      ovf_q    <= ovf_d;
      op_q     <= op;
    end
  end

  assign result = result_q;
  assign zero   = (result_q[31:0] == '0);
  assign sign   = result_q[31];
  assign ovf    = ovf_q;
  assign u      = (op_q == 6'h24) || (op_q == 6'h25);

  // Byte lanes come from the low address bits of the registered result.
  always_comb begin
    be = 4'b0000;
    case (op_q)
      6'h20, 6'h24, 6'h28: be = 4'b0001 << result_q[1:0];
      6'h21, 6'h25, 6'h29: be = result_q[1] ? 4'b1100 : 4'b0011;
      6'h23, 6'h2B:        be = 4'b1111;
      default:             be = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed-vector bench for ex_alu_stage with hand-computed expectations.
module tb_ex_alu_stage;
  logic        clk = 1'b0;
  logic        reset, en;
  logic [3:0]  alu_op;
  logic [5:0]  funct, op;
  logic [31:0] a, b;
  logic [63:0] result;
  logic        zero, sign, ovf, u;
  logic [3:0]  be;
  int unsigned total = 0, bad = 0;

  ex_alu_stage #(.UNDEF_FUNCT_ADD(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en), .alu_op(alu_op), .funct(funct),
    .op(op), .a(a), .b(b), .result(result), .zero(zero), .sign(sign),
    .ovf(ovf), .be(be), .u(u)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Apply one operation with en=1 and sample 1 time unit after the capturing edge.
  task automatic run(input logic [3:0] ao, input logic [5:0] fn, input logic [5:0] opc,
                     input logic [31:0] av, input logic [31:0] bv);
    alu_op = ao; funct = fn; op = opc; a = av; b = bv; en = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; alu_op = '0; funct = '0; op = '0; a = '0; b = '0;
    #2;
    check("rst_result", result, 64'h0);
    check("rst_zero", {63'b0, zero}, 64'h1);
    check("rst_be_u", {59'b0, be, u}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    run(4'b0010, 6'h20, 6'h00, 32'h7FFFFFFF, 32'h1);
    check("add_res", result, 64'h80000000);
    check("add_flags", {61'b0, ovf, sign, zero}, 64'b110);
    run(4'b0010, 6'h21, 6'h00, 32'h7FFFFFFF, 32'h1);
    check("addu_res", result, 64'h80000000);
    check("addu_ovf", {63'b0, ovf}, 64'h0);
    run(4'b0001, 6'h00, 6'h00, 32'h80000000, 32'h1);
    check("sub_res", result, 64'h7FFFFFFF);
    check("sub_ovf", {63'b0, ovf}, 64'h1);
    run(4'b0010, 6'h23, 6'h00, 32'h80000000, 32'h1);
    check("subu_ovf", {63'b0, ovf}, 64'h0);

    run(4'b0010, 6'h03, 6'h00, 32'h4, 32'hF0000000);
    check("sra", result, 64'hFF000000);
    run(4'b0010, 6'h02, 6'h00, 32'h4, 32'hF0000000);
    check("srl", result, 64'h0F000000);
    run(4'b0010, 6'h00, 6'h00, 32'h24, 32'hF0000000);
    check("sll", result, 64'h0);
    check("sll_zero", {63'b0, zero}, 64'h1);
    run(4'b0010, 6'h27, 6'h00, 32'h0F0F0F0F, 32'h00FF00FF);
    check("nor", result, 64'hF000F000);

    run(4'b0110, 6'h00, 6'h00, 32'hFFFFFFFF, 32'h1);
    check("slt", result, 64'h1);
    run(4'b0111, 6'h00, 6'h00, 32'hFFFFFFFF, 32'h1);
    check("sltu", result, 64'h0);
    run(4'b1000, 6'h00, 6'h00, 32'h0, 32'h1234);
    check("lui", result, 64'h12340000);
    run(4'b0010, 6'h3F, 6'h00, 32'h1, 32'h2);
    check("undef_funct", result, 64'h3);
    run(4'b1100, 6'h00, 6'h00, 32'h5, 32'h6);
    check("aluop_c_add", result, 64'hB);

    run(4'b0010, 6'h18, 6'h00, 32'hFFFFFFFE, 32'h3);
`ifdef EX_ALU_STAGE_MULT_EN
    check("mult", result, 64'hFFFFFFFF_FFFFFFFA);
`else
    check("mult_off", result, 64'h0);
`endif
    run(4'b0010, 6'h19, 6'h00, 32'hFFFFFFFE, 32'h3);
`ifdef EX_ALU_STAGE_MULT_EN
    check("multu", result, 64'h00000002_FFFFFFFA);
`else
    check("multu_off", result, 64'h0);
`endif

    run(4'b0000, 6'h00, 6'h28, 32'h3, 32'h0);
    check("be_sb3", {59'b0, be, u}, {59'b0, 4'b1000, 1'b0});
    run(4'b0000, 6'h00, 6'h25, 32'h2, 32'h0);
    check("be_lhu2", {59'b0, be, u}, {59'b0, 4'b1100, 1'b1});
    run(4'b0000, 6'h00, 6'h21, 32'h1, 32'h0);
    check("be_lh1", {59'b0, be, u}, {59'b0, 4'b0011, 1'b0});
    run(4'b0000, 6'h00, 6'h24, 32'h2, 32'h0);
    check("be_lbu2", {59'b0, be, u}, {59'b0, 4'b0100, 1'b1});
    run(4'b0000, 6'h00, 6'h2B, 32'h0, 32'h0);
    check("be_sw", {59'b0, be, u}, {59'b0, 4'b1111, 1'b0});
    run(4'b0000, 6'h00, 6'h0F, 32'h3, 32'h0);
    check("be_other", {59'b0, be, u}, 64'h0);

    run(4'b0000, 6'h00, 6'h29, 32'h12340002, 32'h0);
    en = 1'b0; alu_op = 4'b0101; a = 32'hFFFFFFFF; b = 32'h0; op = 6'h00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_res", result, 64'h12340002);
      check("hold_be", {60'b0, be}, {60'b0, 4'b1100});
    end
    #2 reset = 1'b1;
    #1;
    check("async_rst_res", result, 64'h0);
    check("async_rst_be", {59'b0, be, zero}, 64'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    en = 1'b0;
    @(posedge clk); #1;
    check("no_cap_en0", result, 64'h0);
    run(4'b0000, 6'h00, 6'h00, 32'h10, 32'h20);
    check("first_cap", result, 64'h30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
